// File: rtl/seg_scan_drv.sv
// rtl/seg_scan_drv.sv - 4-digit common-cathode 7-segment scan driver with per-frame BCD snapshot (option: SEG_LEADING_ZERO_BLANK_EN)
module seg_scan_drv #(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);

    typedef enum logic [1:0] {
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [11:0]      snap;
    logic             wrap;
    logic             frame_end;
    logic             dead;
    logic             blank;
    logic [7:0]       pattern;
    logic [3:0]       dig_on;
    logic [7:0]       seg_nxt;
    logic [3:0]       dig_nxt;

    // Segment order {dp,g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 8'h3F;
            4'd1:    seg_decode = 8'h06;
            4'd2:    seg_decode = 8'h5B;
            4'd3:    seg_decode = 8'h4F;
            4'd4:    seg_decode = 8'h66;
            4'd5:    seg_decode = 8'h6D;
            4'd6:    seg_decode = 8'h7D;
            4'd7:    seg_decode = 8'h07;
            4'd8:    seg_decode = 8'h7F;
            4'd9:    seg_decode = 8'h6F;
            default: seg_decode = 8'h40;
        endcase
    endfunction

    always_comb begin
        wrap      = (cnt == CNT_LAST);
        frame_end = wrap && (state == DIG3);
        cnt_nxt   = wrap ? '0 : cnt + 1'b1;
        state_nxt = state;
        if (wrap) begin
            case (state)
                DIG0:    state_nxt = DIG1;
                DIG1:    state_nxt = DIG2;
                DIG2:    state_nxt = DIG3;
                default: state_nxt = DIG0;
            endcase
        end

        dead    = (cnt < DEAD_LIM);
        blank   = 1'b0;
        pattern = 8'h00;
        dig_on  = 4'hF;
        case (state)
            DIG0: begin
                pattern = seg_decode(snap[3:0]);
                dig_on  = 4'b1110;
            end
            DIG1: begin
                pattern = seg_decode(snap[7:4]);
                dig_on  = 4'b1101;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                blank   = (snap[11:8] == 4'd0) && (snap[7:4] == 4'd0);
`endif
            end
            DIG2: begin
                pattern = seg_decode(snap[11:8]);
                dig_on  = 4'b1011;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                blank   = (snap[11:8] == 4'd0);
`endif
            end
            default: begin
                pattern = 8'h39;
                dig_on  = 4'b0111;
            end
        endcase

        // A blanked digit keeps its enable so every position gets the same duty cycle.
        seg_nxt = (dead || blank) ? 8'h00 : pattern;
        dig_nxt = dead ? 4'hF : dig_on;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= DIG0;
            cnt        <= '0;
            snap       <= 12'h000;
            seg        <= 8'h00;
            dig        <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            if (frame_end) begin
                snap <= bcd_in;
            end
            seg        <= seg_nxt;
            dig        <= dig_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb/tb_seg_scan_drv.sv - scoreboard bench for seg_scan_drv (SCAN_DIV=8, DEAD_CYC=2)
module tb_seg_scan_drv;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int LIMIT = 4 * SD;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_tick;

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_q[$];

    seg_scan_drv #(
        .SCAN_DIV(SD),
        .DEAD_CYC(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .seg       (seg),
        .dig       (dig),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_seg(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        return tbl[n];
    endfunction

    // Expected per-slot segment patterns for one frame showing v, in slot order dig0..dig3.
    task automatic push_frame(input logic [11:0] v);
        logic h_blank;
        logic t_blank;
        h_blank = 1'b0;
        t_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        h_blank = (v[11:8] == 4'd0);
        t_blank = (v[11:8] == 4'd0) && (v[7:4] == 4'd0);
`endif
        exp_q.push_back(ref_seg(v[3:0]));
        exp_q.push_back(t_blank ? 8'h00 : ref_seg(v[7:4]));
        exp_q.push_back(h_blank ? 8'h00 : ref_seg(v[11:8]));
        exp_q.push_back(8'h39);
    endtask

    task automatic check_frame(input string name, input int chg_slot, input logic [11:0] chg_val);
        for (int s = 0; s < 4; s++) begin
            int         w;
            logic [3:0] exp_dig;
            logic [7:0] exp_seg;
            w = 0;
            while (dig !== 4'hF && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            w = 0;
            while (dig === 4'hF && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            vectors++;
            if (w >= LIMIT) begin
                miscompares++;
                $display("FAIL %s slot %0d timeout: dig=%h never enabled", name, s, dig);
            end
            exp_dig = ~(4'b0001 << s);
            vectors++;
            if (dig !== exp_dig) begin
                miscompares++;
                $display("FAIL %s slot %0d dig: got %b want %b", name, s, dig, exp_dig);
            end
            exp_seg = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            vectors++;
            if (seg !== exp_seg) begin
                miscompares++;
                $display("FAIL %s slot %0d seg: got %h want %h", name, s, seg, exp_seg);
            end
            if (s == chg_slot) bcd_in = chg_val;
        end
        w_dead: begin
            int w;
            w = 0;
            while (dig !== 4'hF && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
        end
    endtask

    task automatic wait_tick(input string name);
        int w;
        w = 0;
        while (frame_tick !== 1'b1 && w < 2 * LIMIT) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w >= 2 * LIMIT) begin
            miscompares++;
            $display("FAIL %s frame_tick timeout", name);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bcd_in = 12'h025;
        repeat (3) @(negedge clk);
        vectors++;
        if (dig !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_dig: got %h want f", dig);
        end
        vectors++;
        if (seg !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_seg: got %h want 00", seg);
        end
        vectors++;
        if (frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick: got %b want 0", frame_tick);
        end
    endtask

    // Cycle-exact check of the first two frames after reset release (snap 000, then 025).
    task automatic test_timing();
        logic [7:0] cur;
        cur = 8'h00;
        push_frame(12'h000);
        push_frame(12'h025);
        rst_n = 1'b1;
        for (int k = 1; k <= 2 * 4 * SD; k++) begin
            int         p;
            int         s;
            logic [3:0] exp_dig;
            logic [7:0] exp_seg;
            logic       exp_tick;
            @(negedge clk);
            p = (k - 1) % SD;
            s = ((k - 1) / SD) % 4;
            if (p == DC) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            exp_dig  = (p < DC) ? 4'hF : ~(4'b0001 << s);
            exp_seg  = (p < DC) ? 8'h00 : cur;
            exp_tick = (k % (4 * SD)) == 0;
            vectors++;
            if (dig !== exp_dig) begin
                miscompares++;
                $display("FAIL timing_dig cyc %0d: got %b want %b", k, dig, exp_dig);
            end
            vectors++;
            if (seg !== exp_seg) begin
                miscompares++;
                $display("FAIL timing_seg cyc %0d: got %h want %h", k, seg, exp_seg);
            end
            vectors++;
            if (frame_tick !== exp_tick) begin
                miscompares++;
                $display("FAIL timing_tick cyc %0d: got %b want %b", k, frame_tick, exp_tick);
            end
            vectors++;
            if ($countones(~dig) > 1) begin
                miscompares++;
                $display("FAIL one_hot cyc %0d: got %b want at most one low", k, dig);
            end
        end
    endtask

    task automatic test_snapshot();
        bcd_in = 12'h123;
        push_frame(12'h025);
        check_frame("snap_old", -1, 12'h000);
        push_frame(12'h123);
        check_frame("snap_mid", 1, 12'h456);
        push_frame(12'h456);
        check_frame("snap_new", -1, 12'h000);
    endtask

    task automatic test_invalid();
        bcd_in = 12'h0A7;
        push_frame(12'h456);
        check_frame("inv_prev", -1, 12'h000);
        push_frame(12'h0A7);
        check_frame("invalid", -1, 12'h000);
    endtask

    task automatic test_zero();
        bcd_in = 12'h000;
        push_frame(12'h0A7);
        check_frame("zero_prev", -1, 12'h000);
        push_frame(12'h000);
        check_frame("zero", -1, 12'h000);
    endtask

    task automatic test_reset_mid();
        int w;
        bcd_in = 12'h987;
        w = 0;
        while (dig !== 4'b1011 && w < 2 * LIMIT) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w >= 2 * LIMIT) begin
            miscompares++;
            $display("FAIL rmid_find_dig2 timeout: dig=%b", dig);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (dig !== 4'hF || seg !== 8'h00 || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_abort: got dig=%h seg=%h tick=%b want f/00/0", dig, seg, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= DC; k++) begin
            @(negedge clk);
            vectors++;
            if (dig !== 4'hF) begin
                miscompares++;
                $display("FAIL rmid_dead cyc %0d: got %h want f", k, dig);
            end
        end
        @(negedge clk);
        vectors++;
        if (dig !== 4'b1110 || seg !== 8'h3F) begin
            miscompares++;
            $display("FAIL rmid_restart: got dig=%b seg=%h want 1110/3f", dig, seg);
        end
        wait_tick("rmid_tick");
        push_frame(12'h987);
        check_frame("rmid_next", -1, 12'h000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bcd_in      = 12'h000;
        test_reset();
        test_timing();
        test_snapshot();
        test_invalid();
        test_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
